// File: rtl/dror_dispatch_controller.sv
// Streams points into validator cores, retires finished cores round-robin and queues outlier indices.
// Optional retire statistics are enabled by defining DROR_DISPATCH_STATS_EN.
module dror_dispatch_controller #(
    parameter int N           = 16,
    parameter int IDX_W       = 32,
    parameter int CORE_NUMBER = 16,
    parameter int FIFO_DEPTH  = 64
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_start,
    input  logic [IDX_W-1:0]         i_point_cloud_size,
    input  logic                     i_pause,
    input  logic                     i_pt_valid,
    output logic                     o_pt_ready,
    input  logic [N-1:0]             i_pt_x,
    input  logic [N-1:0]             i_pt_y,
    input  logic [N-1:0]             i_pt_z,
    output logic [N*CORE_NUMBER-1:0] o_core_x,
    output logic [N*CORE_NUMBER-1:0] o_core_y,
    output logic [N*CORE_NUMBER-1:0] o_core_z,
    output logic [CORE_NUMBER-1:0]   o_core_reset,
    input  logic [CORE_NUMBER-1:0]   i_core_inlier,
    input  logic [CORE_NUMBER-1:0]   i_core_outlier,
    output logic                     o_out_valid,
    input  logic                     i_out_ready,
    output logic [IDX_W-1:0]         o_out_idx,
    output logic                     o_busy,
    output logic                     o_done,
    output logic [IDX_W-1:0]         o_inlier_count,
    output logic [IDX_W-1:0]         o_outlier_count
);

    localparam int CW = (CORE_NUMBER > 1) ? $clog2(CORE_NUMBER) : 1;
    localparam int FW = $clog2(FIFO_DEPTH);
    localparam logic [FW:0]   FIFO_FULL = (FW+1)'(FIFO_DEPTH);
    localparam logic [CW-1:0] LAST_SLOT = CW'(CORE_NUMBER - 1);
    localparam logic [CW:0]   CORE_NUM  = (CW+1)'(CORE_NUMBER);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t                  r_state;
    logic                    r_busy;
    logic                    r_done;
    logic [CORE_NUMBER-1:0]  r_active;
    logic [CORE_NUMBER-1:0]  r_core_reset;
    logic [IDX_W-1:0]        r_idx [CORE_NUMBER];
    logic [N*CORE_NUMBER-1:0] r_x;
    logic [N*CORE_NUMBER-1:0] r_y;
    logic [N*CORE_NUMBER-1:0] r_z;
    logic [IDX_W-1:0]        r_next_idx;
    logic [IDX_W-1:0]        r_size;
    logic [CW-1:0]           r_rr_ptr;

    logic [IDX_W-1:0]        r_fifo [FIFO_DEPTH];
    logic [FW-1:0]           r_wr_ptr;
    logic [FW-1:0]           r_rd_ptr;
    logic [FW:0]             r_count;

    logic                    w_run;
    logic                    w_go;
    logic                    w_pt_ready;
    logic                    w_load;
    logic [CW-1:0]           w_load_slot;
    logic [CORE_NUMBER-1:0]  w_elig;
    logic                    w_found;
    logic [CW-1:0]           w_sel_slot;
    logic                    w_sel_out;
    logic                    w_full;
    logic                    w_retire;
    logic                    w_push;
    logic                    w_pop;
    logic [CW-1:0]           w_rr_next;

    assign w_run      = (r_state == S_RUN);
    assign w_go       = w_run && !i_pause;
    assign w_pt_ready = w_go && (r_next_idx < r_size) && !(&r_active);
    assign w_load     = w_pt_ready && i_pt_valid;
    assign w_elig     = r_active & ~r_core_reset & (i_core_inlier | i_core_outlier);
    assign w_full     = (r_count == FIFO_FULL);
    assign w_retire   = w_go && w_found && !(w_sel_out && w_full);
    assign w_push     = w_retire && w_sel_out;
    assign w_pop      = (r_count != '0) && i_out_ready;
    assign w_rr_next  = (w_sel_slot == LAST_SLOT) ? '0 : w_sel_slot + 1'b1;

    always_comb begin
        w_load_slot = '0;
        for (int i = CORE_NUMBER - 1; i >= 0; i--) begin
            if (!r_active[i]) w_load_slot = CW'(i);
        end
    end

    // Scan slots starting at rr_ptr, wrapping at CORE_NUMBER (not necessarily a power of two).
    always_comb begin : arb
        logic [CW:0] j;
        w_found    = 1'b0;
        w_sel_slot = '0;
        w_sel_out  = 1'b0;
        j          = '0;
        for (int k = 0; k < CORE_NUMBER; k++) begin
            j = {1'b0, r_rr_ptr} + (CW+1)'(k);
            if (j >= CORE_NUM) j = j - CORE_NUM;
            if (!w_found && w_elig[j[CW-1:0]]) begin
                w_found    = 1'b1;
                w_sel_slot = j[CW-1:0];
                w_sel_out  = i_core_outlier[j[CW-1:0]];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= S_IDLE;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_active     <= '0;
            r_core_reset <= '1;
            r_x          <= '0;
            r_y          <= '0;
            r_z          <= '0;
            r_next_idx   <= '0;
            r_size       <= '0;
            r_rr_ptr     <= '0;
            for (int i = 0; i < CORE_NUMBER; i++) r_idx[i] <= '0;
        end else begin
            r_core_reset <= ~r_active;
            unique case (r_state)
                S_IDLE, S_DONE: begin
                    if (i_start) begin
                        r_state    <= S_RUN;
                        r_busy     <= 1'b1;
                        r_done     <= 1'b0;
                        r_next_idx <= '0;
                        r_size     <= i_point_cloud_size;
                        r_rr_ptr   <= '0;
                        r_active   <= '0;
                    end
                end
                S_RUN: begin
                    if (r_next_idx == r_size && r_active == '0) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                    if (w_load) begin
                        r_active[w_load_slot]      <= 1'b1;
                        r_idx[w_load_slot]         <= r_next_idx;
                        r_x[w_load_slot*N +: N]    <= i_pt_x;
                        r_y[w_load_slot*N +: N]    <= i_pt_y;
                        r_z[w_load_slot*N +: N]    <= i_pt_z;
                        r_next_idx                 <= r_next_idx + 1'b1;
                    end
                    if (w_retire) begin
                        r_active[w_sel_slot] <= 1'b0;
                        r_rr_ptr             <= w_rr_next;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) r_fifo[r_wr_ptr] <= r_idx[w_sel_slot];
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef DROR_DISPATCH_STATS_EN
    logic [IDX_W-1:0] r_inl_cnt;
    logic [IDX_W-1:0] r_out_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_inl_cnt <= '0;
            r_out_cnt <= '0;
        end else if (i_start && !w_run) begin
            r_inl_cnt <= '0;
            r_out_cnt <= '0;
        end else if (w_retire) begin
            if (w_sel_out) begin
                if (!(&r_out_cnt)) r_out_cnt <= r_out_cnt + 1'b1;
            end else begin
                if (!(&r_inl_cnt)) r_inl_cnt <= r_inl_cnt + 1'b1;
            end
        end
    end

    assign o_inlier_count  = r_inl_cnt;
    assign o_outlier_count = r_out_cnt;
`else
    assign o_inlier_count  = '0;
    assign o_outlier_count = '0;
`endif

    assign o_pt_ready   = w_pt_ready;
    assign o_core_x     = r_x;
    assign o_core_y     = r_y;
    assign o_core_z     = r_z;
    assign o_core_reset = r_core_reset;
    assign o_out_valid  = (r_count != '0);
    assign o_out_idx    = (r_count != '0) ? r_fifo[r_rd_ptr] : '0;
    assign o_busy       = r_busy;
    assign o_done       = r_done;

endmodule

// File: tb/tb_dror_dispatch_controller.sv
// Bench for dror_dispatch_controller with 4 cores and a 2-entry outlier FIFO:
// frame table plus stall, arbitration, pause and reset sequences.
module tb_dror_dispatch_controller;

    localparam int N  = 16;
    localparam int IW = 32;
    localparam int C  = 4;
    localparam int D  = 2;
`ifdef DROR_DISPATCH_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    typedef struct {
        int          size;
        logic [31:0] mask;
        int          nout;
        logic [3:0][7:0] seq;
        int          ninl;
    } vec_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic            start = 1'b0;
    logic            pause = 1'b0;
    logic            pt_valid = 1'b0;
    logic            out_ready = 1'b0;
    logic [IW-1:0]   size = '0;
    logic [N-1:0]    pt_x = '0;
    logic [N-1:0]    pt_y;
    logic [N-1:0]    pt_z;
    logic            pt_ready;
    logic [N*C-1:0]  core_x;
    logic [N*C-1:0]  core_y;
    logic [N*C-1:0]  core_z;
    logic [C-1:0]    core_reset;
    logic [C-1:0]    core_inl;
    logic [C-1:0]    core_out;
    logic            out_valid;
    logic [IW-1:0]   out_idx;
    logic            busy;
    logic            done;
    logic [IW-1:0]   inl_cnt;
    logic [IW-1:0]   out_cnt;

    logic            auto_mode = 1'b1;
    logic [C-1:0]    man_inl = '0;
    logic [C-1:0]    man_out = '0;
    logic [C-1:0]    m_inl = '0;
    logic [C-1:0]    m_out = '0;
    logic [31:0]     omask = '0;
    int              cnt [C];
    int              sent = 0;
    int              acc = 0;
    int              cyc = 0;
    bit              ov_seen = 1'b0;
    int              pops [$];
    int              pop_cyc [$];
    int              total = 0;
    int              bad = 0;
    vec_t            tv [5];

    assign pt_y     = pt_x ^ 16'h00ff;
    assign pt_z     = pt_x + 16'h1000;
    assign core_inl = auto_mode ? m_inl : man_inl;
    assign core_out = auto_mode ? m_out : man_out;

    always #5 clk = ~clk;

    dror_dispatch_controller #(
        .N(N), .IDX_W(IW), .CORE_NUMBER(C), .FIFO_DEPTH(D)
    ) dut (
        .i_clk(clk),
        .i_rst_n(rst_n),
        .i_start(start),
        .i_point_cloud_size(size),
        .i_pause(pause),
        .i_pt_valid(pt_valid),
        .o_pt_ready(pt_ready),
        .i_pt_x(pt_x),
        .i_pt_y(pt_y),
        .i_pt_z(pt_z),
        .o_core_x(core_x),
        .o_core_y(core_y),
        .o_core_z(core_z),
        .o_core_reset(core_reset),
        .i_core_inlier(core_inl),
        .i_core_outlier(core_out),
        .o_out_valid(out_valid),
        .i_out_ready(out_ready),
        .o_out_idx(out_idx),
        .o_busy(busy),
        .o_done(done),
        .o_inlier_count(inl_cnt),
        .o_outlier_count(out_cnt)
    );

    // Each core raises its verdict 3 cycles after leaving reset; outlier if its base x is in omask.
    always @(posedge clk) begin
        #1;
        pt_x = sent[N-1:0];
        for (int i = 0; i < C; i++) begin
            if (core_reset[i]) begin
                cnt[i]   = 0;
                m_inl[i] = 1'b0;
                m_out[i] = 1'b0;
            end else begin
                if (cnt[i] < 3) cnt[i]++;
                if (cnt[i] >= 3) begin
                    if (omask[core_x[i*N +: N]]) m_out[i] = 1'b1;
                    else m_inl[i] = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        cyc++;
        if (start && !busy) begin
            sent    = 0;
            acc     = 0;
            ov_seen = 1'b0;
        end
        if (pt_valid && pt_ready) begin
            sent++;
            acc++;
        end
        if (out_valid) ov_seen = 1'b1;
        if (out_valid && out_ready) begin
            pops.push_back(int'(out_idx));
            pop_cyc.push_back(cyc);
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic begin_frame(input int sz);
        pops.delete();
        pop_cyc.delete();
        size  = sz;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int lim, input string nm);
        int n;
        n = 0;
        while (!done && n < lim) begin
            tick();
            n++;
        end
        chk(nm, done, 1);
    endtask

    initial begin
        tv[0] = '{size: 10, mask: 32'h0,    nout: 0, seq: {8'd0, 8'd0, 8'd0, 8'd0},  ninl: 10};
        tv[1] = '{size: 10, mask: 32'h224,  nout: 3, seq: {8'd0, 8'd9, 8'd5, 8'd2},  ninl: 7};
        tv[2] = '{size: 1,  mask: 32'h1,    nout: 1, seq: {8'd0, 8'd0, 8'd0, 8'd0},  ninl: 0};
        tv[3] = '{size: 16, mask: 32'h8001, nout: 2, seq: {8'd0, 8'd0, 8'd15, 8'd0}, ninl: 14};
        tv[4] = '{size: 4,  mask: 32'hF,    nout: 4, seq: {8'd3, 8'd2, 8'd1, 8'd0},  ninl: 0};

        pt_valid = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst core_reset", core_reset, 4'hF);
        chk("rst core_x", core_x, 0);
        chk("rst out_valid", out_valid, 0);
        chk("rst out_idx", out_idx, 0);
        chk("rst pt_ready", pt_ready, 0);
        chk("rst inl_cnt", inl_cnt, 0);
        chk("rst out_cnt", out_cnt, 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        out_ready = 1'b1;
        auto_mode = 1'b1;
        for (int v = 0; v < 5; v++) begin
            omask = tv[v].mask;
            begin_frame(tv[v].size);
            wait_done(300, $sformatf("v%0d done", v));
            tick();
            tick();
            chk($sformatf("v%0d accepts", v), acc, tv[v].size);
            chk($sformatf("v%0d npops", v), pops.size(), tv[v].nout);
            for (int k = 0; k < tv[v].nout && k < pops.size(); k++)
                chk($sformatf("v%0d pop%0d", v, k), pops[k], int'(tv[v].seq[k]));
            chk($sformatf("v%0d ov_seen", v), ov_seen, tv[v].nout > 0);
            chk($sformatf("v%0d inl_cnt", v), inl_cnt, STATS ? tv[v].ninl : 0);
            chk($sformatf("v%0d out_cnt", v), out_cnt, STATS ? tv[v].nout : 0);
            chk($sformatf("v%0d busy", v), busy, 0);
        end

        omask     = 32'hFF;
        out_ready = 1'b0;
        begin_frame(8);
        repeat (25) tick();
        chk("stall out_valid", out_valid, 1);
        chk("stall out_idx", out_idx, 0);
        chk("stall pt_ready", pt_ready, 0);
        chk("stall busy", busy, 1);
        chk("stall accepts", acc, 6);
        chk("stall core_reset", core_reset, 4'h0);
        out_ready = 1'b1;
        wait_done(200, "stall done");
        tick();
        chk("stall npops", pops.size(), 8);
        for (int k = 0; k < 8 && k < pops.size(); k++)
            chk($sformatf("stall pop%0d", k), pops[k], k);
        chk("stall out_cnt", out_cnt, STATS ? 8 : 0);

        auto_mode = 1'b0;
        man_inl   = '0;
        man_out   = '0;
        begin_frame(5);
        repeat (8) tick();
        chk("rr core_reset", core_reset, 4'h0);
        chk("rr core_x", core_x, {16'd3, 16'd2, 16'd1, 16'd0});
        chk("rr core_y", core_y, {16'h00fc, 16'h00fd, 16'h00fe, 16'h00ff});
        chk("rr core_z", core_z, {16'h1003, 16'h1002, 16'h1001, 16'h1000});
        chk("rr pt_ready full", pt_ready, 0);
        man_inl = 4'b0010;
        tick();
        man_inl = '0;
        chk("rr pt_ready freed", pt_ready, 1);
        repeat (4) tick();
        chk("rr reload x", core_x[31:16], 4);
        chk("rr reload core_reset", core_reset, 4'h0);
        man_out = 4'hF;
        wait_done(50, "rr done");
        man_out = '0;
        tick();
        chk("rr npops", pops.size(), 4);
        if (pops.size() == 4) begin
            chk("rr pop0", pops[0], 2);
            chk("rr pop1", pops[1], 3);
            chk("rr pop2", pops[2], 0);
            chk("rr pop3", pops[3], 4);
            for (int k = 0; k < 3; k++)
                chk($sformatf("rr gap%0d", k), pop_cyc[k+1] - pop_cyc[k], 1);
        end

        auto_mode = 1'b1;
        omask     = 32'hFFF;
        out_ready = 1'b0;
        begin_frame(12);
        repeat (25) tick();
        chk("pause pre npops", pops.size(), 0);
        pause     = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk($sformatf("pause pt_ready%0d", k), pt_ready, 0);
        end
        chk("pause npops", pops.size(), 2);
        if (pops.size() == 2) begin
            chk("pause pop0", pops[0], 0);
            chk("pause pop1", pops[1], 1);
        end
        chk("pause out_valid", out_valid, 0);
        pause = 1'b0;
        tick();
        chk("resume out_valid", out_valid, 1);
        chk("resume out_idx", out_idx, 2);
        wait_done(200, "pause done");
        tick();
        chk("pause total pops", pops.size(), 12);

        omask = 32'h0;
        begin_frame(20);
        repeat (6) tick();
        #3 rst_n = 1'b0;
        #1;
        chk("mid rst busy", busy, 0);
        chk("mid rst done", done, 0);
        chk("mid rst core_reset", core_reset, 4'hF);
        chk("mid rst out_valid", out_valid, 0);
        chk("mid rst pt_ready", pt_ready, 0);
        chk("mid rst core_x", core_x, 0);
        tick();
        rst_n = 1'b1;
        tick();
        begin_frame(0);
        chk("size0 busy", busy, 1);
        chk("size0 done early", done, 0);
        tick();
        chk("size0 done", done, 1);
        chk("size0 busy low", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
